mmio_io_ctrl: RTL and testbench
===============================

# mmio_io_ctrl

Parametrised memory-mapped I/O controller for the riscvmulti SoC. It sits behind the `addr[8]` I/O window and replaces the inline LED/HEX/KEY/SW decode in the top level with a single register block. It adds:
- synchronised, debounced inputs;
- sticky key-press capture with write-1-to-clear;
- a loadable 32-bit timer;
- a maskable interrupt output.

## Interface
Parameters:
- `LED_W`, 10, LED output width (≤32)
- `KEY_W`, 4, number of push keys (≤32)
- `SW_W`, 10, number of slide switches (≤32)
- `HEX_DIGITS`, 6, number of 4-bit display nibbles (≤8)
- `DEB_CYCLES`, 4, consecutive stable samples needed to accept an input change (≥1)

Ports:
- `clk`, input, 1, CPU clock. One clock domain. Reset is synchronous and active-low.
- `reset`, input, 1, synchronous, active-low reset.
- `sel`, input, 1, I/O window selected; driven from `addr[8]`.
- `we`, input, 1, write strobe; qualified by `sel`.
- `addr`, input, 5, byte offset within the window; `addr[4:2]` selects the register.
- `wdata`, input, 32, write data.
- `rdata`, output, 32, read data (combinational).
- `key_n`, input, KEY_W, raw keys, active-low, asynchronous.
- `sw`, input, SW_W, raw switches, asynchronous.
- `ledr`, output, LED_W, LED register.
- `hex_nib`, output, 4*HEX_DIGITS, display nibbles; digit 0 is `[3:0]`.
- `irq`, output, 1, level interrupt.

## Operation
Register map (word index = `addr[4:2]`):
- 0 `LEDS`: R/W, `wdata[LED_W-1:0]`.
- 1 `HEX`: R/W, `wdata[4*HEX_DIGITS-1:0]`.
- 2 `KEY`: RO, debounced key level, active-high (1 = pressed).
- 3 `KEYEDGE`: sticky press flags. Writing 1 to a bit clears it; writing 0 leaves it unchanged.
- 4 `SW`: RO, debounced switch level.
- 5 `TIMER`: R/W. Free-running; a write loads the value.
- 6 `IRQEN`: R/W, `wdata[KEY_W-1:0]`, per-key interrupt enable.
- 7: reserved. Reads 0, writes ignored.

Access rules:
- Reads return fields zero-extended to 32 bits. Reads have no side effects.
- `rdata` = 0 when `sel`=0.
- Writes to RO registers are ignored.

Input path, per bit:
- 2-flop synchroniser. Key synchronisers reset to 1 (released); switch synchronisers reset to 0.
- Debouncer: if the synchronised bit differs from the accepted level for `DEB_CYCLES` consecutive cycles, the level is updated. Any matching sample clears the counter.
- Keys are inverted after synchronisation, so level 1 = pressed.

Edge capture:
- A 0→1 transition of the accepted key level sets `KEYEDGE[i]`.
- If the set and a W1C land in the same cycle, set wins.
- Key releases do not set a flag.

Timer:
- Increments by 1 every cycle and wraps 0xFFFF_FFFF → 0.
- In a write cycle, the next value is `wdata`. The load replaces the increment, and counting resumes the cycle after.

Interrupt:
- `irq` = OR over i of (`KEYEDGE[i]` & `IRQEN[i]`), combinational from registered state.

Reset values (`reset`=0 at a clock edge):
- `ledr`, `hex_nib`, `KEY` level, `SW` level, `KEYEDGE`, `IRQEN`, `TIMER`, and the debounce counters = 0.
- `irq` = 0.
- Reset mid-debounce discards partial counts.

## Timing
- Write effect: visible on outputs and read-back at the clock edge where `sel & we`. Read-back on the next cycle returns the new value.
- Read latency: 0 (combinational). This matches the riscvmulti memory-read timing.
- Input latency: a raw change stable from edge 0 appears in `KEY`/`SW` after edge 2+`DEB_CYCLES`.
  - `KEYEDGE` and `irq` assert at that same edge.
  - Pulses shorter than `DEB_CYCLES` synchronised cycles are rejected.
- W1C: the flag is clear after the write edge, and `irq` falls in the same cycle, unless a new press sets the flag that edge.
- All state updates on rising `clk`. No combinational path from `key_n`/`sw` to any output.

## Structure
- Package `mmio_io_pkg`: register index localparams (`REG_LEDS`…`REG_IRQEN`), window base 0x100, reset constants.
- Sub-module `io_debounce`: one instance per key bit and per switch bit.
  - Parameters `DEB_CYCLES` and `RESET_VAL`.
  - Contains the synchroniser, the counter (width `$clog2(DEB_CYCLES+1)`) and the accepted level.
- Top level instantiates `mmio_io_ctrl` with `sel = addr[8]` and keeps `dec7seg` on `hex_nib`.

## Test plan
- Reset: drive `reset`=0 for 2 cycles, then release.
  - Required: `ledr`=0, `hex_nib`=0, `irq`=0.
  - Required: reads of all registers return 0, including offset 0x1C.
- Write `LEDS`=0xFFFF_FFFF, then `HEX`=0x00AB_CDEF.
  - Required: `ledr`=0x3FF and `hex_nib`=0xABCDEF next cycle.
  - Required: reads return 0x3FF and 0xABCDEF.
- Debounce and interrupt, with `DEB_CYCLES`=4:
  - Hold `key_n[1]`=0 for 3 cycles, then 1 → `KEY`, `KEYEDGE` unchanged.
  - Then hold `key_n[1]`=0 → `KEY`=0x2 and `KEYEDGE`=0x2 after 6 edges.
  - With `IRQEN`=0x2, `irq`=1.
- W1C race: write `KEYEDGE`=0x2 in the same cycle a new key-2 press is accepted.
  - Required: `KEYEDGE`=0x4.
  - Required: `irq`=0 if `IRQEN`=0x2.
- Timer:
  - Write 0xFFFF_FFFE → reads 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0 on the following cycles.
  - Write to `KEY` (RO) → no change.
- Reset mid-debounce: assert `reset` 2 cycles into a switch change.
  - Required: `SW`=0.
  - Required: the full 2+`DEB_CYCLES` latency applies after release.

Source files
------------

// File: rtl/mmio_io_pkg.sv
// Register map, window base and reset constants for the MMIO I/O block.
package mmio_io_pkg;

    localparam logic [2:0] REG_LEDS    = 3'd0;
    localparam logic [2:0] REG_HEX     = 3'd1;
    localparam logic [2:0] REG_KEY     = 3'd2;
    localparam logic [2:0] REG_KEYEDGE = 3'd3;
    localparam logic [2:0] REG_SW      = 3'd4;
    localparam logic [2:0] REG_TIMER   = 3'd5;
    localparam logic [2:0] REG_IRQEN   = 3'd6;
    localparam logic [2:0] REG_RSVD    = 3'd7;

    localparam logic [31:0] IO_BASE = 32'h0000_0100;

    // Keys idle high (released), switches idle low.
    localparam logic        KEY_SYNC_RST = 1'b1;
    localparam logic        SW_SYNC_RST  = 1'b0;
    localparam logic [31:0] TIMER_RST    = 32'h0000_0000;

    // Byte offset of a register within the window.
    function automatic logic [4:0] reg_off(input logic [2:0] idx);
        return {idx, 2'b00};
    endfunction

endpackage

// File: rtl/io_debounce.sv
// Purpose: 2-flop synchroniser plus stable-sample debouncer for one raw input bit.
// Latency: a change sampled at edge 1 is accepted at edge 2+DEB_CYCLES.
// Backpressure: none; free-running, update pulses the cycle before level flips.
module io_debounce #(
    parameter int   DEB_CYCLES = 4,
    parameter logic RESET_VAL  = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic update
);

    localparam int             CW       = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync_q1;
    logic          sync_q2;
    logic [CW-1:0] cnt;

    assign update = (sync_q2 != level) && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q1 <= RESET_VAL;
            sync_q2 <= RESET_VAL;
            level   <= RESET_VAL;
            cnt     <= '0;
        end else begin
            sync_q1 <= din;
            sync_q2 <= sync_q1;
            if (sync_q2 == level) begin
                cnt <= '0;
            end else if (update) begin
                level <= sync_q2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/mmio_io_ctrl.sv
// Purpose: MMIO register block for LEDs, HEX nibbles, debounced keys/switches, timer and key IRQ.
// Latency: writes land at the strobe edge; reads are combinational (0 cycles).
// Backpressure: none; every access completes in the cycle it is presented.
module mmio_io_ctrl
    import mmio_io_pkg::*;
#(
    parameter int LED_W      = 10,
    parameter int KEY_W      = 4,
    parameter int SW_W       = 10,
    parameter int HEX_DIGITS = 6,
    parameter int DEB_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sel,
    input  logic                    we,
    input  logic [4:0]              addr,
    input  logic [31:0]             wdata,
    output logic [31:0]             rdata,
    input  logic [KEY_W-1:0]        key_n,
    input  logic [SW_W-1:0]         sw,
    output logic [LED_W-1:0]        ledr,
    output logic [4*HEX_DIGITS-1:0] hex_nib,
    output logic                    irq
);

    logic [2:0]       reg_idx;
    logic [1:0]       addr_lo_unused;
    logic             wr_vld;
    logic [KEY_W-1:0] key_raw_lvl;
    logic [KEY_W-1:0] key_upd;
    logic [KEY_W-1:0] key_lvl;
    logic [KEY_W-1:0] key_set;
    logic [KEY_W-1:0] key_w1c;
    logic [KEY_W-1:0] key_edge;
    logic [KEY_W-1:0] irq_en;
    logic [SW_W-1:0]  sw_lvl;
    logic [SW_W-1:0]  sw_upd_unused;
    logic [31:0]      timer;

    assign reg_idx        = addr[4:2];
    assign addr_lo_unused = addr[1:0];
    assign wr_vld         = sel & we;

    for (genvar i = 0; i < KEY_W; i++) begin : g_key
        io_debounce #(.DEB_CYCLES(DEB_CYCLES), .RESET_VAL(KEY_SYNC_RST)) u_deb (
            .clk    (clk),
            .reset  (reset),
            .din    (key_n[i]),
            .level  (key_raw_lvl[i]),
            .update (key_upd[i])
        );
    end

    for (genvar i = 0; i < SW_W; i++) begin : g_sw
        io_debounce #(.DEB_CYCLES(DEB_CYCLES), .RESET_VAL(SW_SYNC_RST)) u_deb (
            .clk    (clk),
            .reset  (reset),
            .din    (sw[i]),
            .level  (sw_lvl[i]),
            .update (sw_upd_unused[i])
        );
    end

    // A press is an accepted raw 1->0 change; it lands on the same edge as the level.
    assign key_lvl = ~key_raw_lvl;
    assign key_set = key_upd & key_raw_lvl;
    assign key_w1c = (wr_vld && reg_idx == REG_KEYEDGE) ? wdata[KEY_W-1:0] : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            ledr     <= '0;
            hex_nib  <= '0;
            key_edge <= '0;
            irq_en   <= '0;
            timer    <= TIMER_RST;
        end else begin
            if (wr_vld && reg_idx == REG_LEDS)  ledr    <= wdata[LED_W-1:0];
            if (wr_vld && reg_idx == REG_HEX)   hex_nib <= wdata[4*HEX_DIGITS-1:0];
            if (wr_vld && reg_idx == REG_IRQEN) irq_en  <= wdata[KEY_W-1:0];
            key_edge <= (key_edge & ~key_w1c) | key_set;
            timer    <= (wr_vld && reg_idx == REG_TIMER) ? wdata : timer + 32'd1;
        end
    end

    assign irq = |(key_edge & irq_en);

    always_comb begin
        rdata = '0;
        if (sel) begin
            case (reg_idx)
                REG_LEDS:    rdata = 32'(ledr);
                REG_HEX:     rdata = 32'(hex_nib);
                REG_KEY:     rdata = 32'(key_lvl);
                REG_KEYEDGE: rdata = 32'(key_edge);
                REG_SW:      rdata = 32'(sw_lvl);
                REG_TIMER:   rdata = timer;
                REG_IRQEN:   rdata = 32'(irq_en);
                REG_RSVD:    rdata = '0;
                default:     rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Bench for mmio_io_ctrl: directed register/debounce/W1C/timer cases, then random traffic vs a window-based model.
`timescale 1ns/1ps
module tb_mmio_io_ctrl;
    import mmio_io_pkg::*;

    localparam int LED_W = 10, KEY_W = 4, SW_W = 10, HEX_DIGITS = 6, DEB = 4;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    sel;
    logic                    we;
    logic [4:0]              addr;
    logic [31:0]             wdata;
    logic [31:0]             rdata;
    logic [KEY_W-1:0]        key_n;
    logic [SW_W-1:0]         sw;
    logic [LED_W-1:0]        ledr;
    logic [4*HEX_DIGITS-1:0] hex_nib;
    logic                    irq;

    int n_tests = 0;
    int n_fail  = 0;

    mmio_io_ctrl #(
        .LED_W(LED_W), .KEY_W(KEY_W), .SW_W(SW_W),
        .HEX_DIGITS(HEX_DIGITS), .DEB_CYCLES(DEB)
    ) dut (
        .clk(clk), .reset(reset), .sel(sel), .we(we), .addr(addr),
        .wdata(wdata), .rdata(rdata), .key_n(key_n), .sw(sw),
        .ledr(ledr), .hex_nib(hex_nib), .irq(irq)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: the debouncer is a window over the last DEB synchronised samples.
    logic [LED_W-1:0]        m_led = '0;
    logic [4*HEX_DIGITS-1:0] m_hex = '0;
    logic [KEY_W-1:0]        m_key = '0, m_edge = '0, m_irqen = '0;
    logic [SW_W-1:0]         m_sw = '0;
    logic [31:0]             m_timer = '0;
    logic [KEY_W-1:0]        k_d1 = '1, k_d2 = '1;
    logic [SW_W-1:0]         s_d1 = '0, s_d2 = '0;
    bit                      r_d1 = 1'b1;
    logic [KEY_W-1:0]        k_win [DEB];
    logic [SW_W-1:0]         s_win [DEB];

    task automatic model_step();
        logic [KEY_W-1:0] ks, kdiff, kw1c;
        logic [SW_W-1:0]  ss, sdiff;
        bit               wr;
        // Value the synchronisers present this edge: raw input two edges ago, or rest value after reset.
        ks = r_d1 ? '0 : ~k_d2;
        ss = r_d1 ? '0 : s_d2;
        k_d2 = k_d1;
        s_d2 = s_d1;
        k_d1 = reset ? key_n : '1;
        s_d1 = reset ? sw : '0;
        r_d1 = !reset;
        for (int j = DEB - 1; j > 0; j--) begin
            k_win[j] = k_win[j-1];
            s_win[j] = s_win[j-1];
        end
        k_win[0] = ks;
        s_win[0] = ss;
        if (!reset) begin
            m_led = '0; m_hex = '0; m_key = '0; m_edge = '0;
            m_irqen = '0; m_sw = '0; m_timer = '0;
            for (int j = 0; j < DEB; j++) begin
                k_win[j] = '0;
                s_win[j] = '0;
            end
        end else begin
            wr = sel && we;
            kdiff = '1;
            sdiff = '1;
            for (int j = 0; j < DEB; j++) begin
                kdiff &= k_win[j] ^ m_key;
                sdiff &= s_win[j] ^ m_sw;
            end
            kw1c   = (wr && addr[4:2] == REG_KEYEDGE) ? wdata[KEY_W-1:0] : '0;
            m_edge = (m_edge & ~kw1c) | (kdiff & ~m_key);
            m_key  = m_key ^ kdiff;
            m_sw   = m_sw ^ sdiff;
            if (wr && addr[4:2] == REG_LEDS)  m_led   = wdata[LED_W-1:0];
            if (wr && addr[4:2] == REG_HEX)   m_hex   = wdata[4*HEX_DIGITS-1:0];
            if (wr && addr[4:2] == REG_IRQEN) m_irqen = wdata[KEY_W-1:0];
            m_timer = (wr && addr[4:2] == REG_TIMER) ? wdata : m_timer + 32'd1;
        end
    endtask

    function automatic logic [31:0] model_rd(input logic s, input logic [4:0] a);
        if (!s) return 32'h0;
        case (a[4:2])
            REG_LEDS:    return 32'(m_led);
            REG_HEX:     return 32'(m_hex);
            REG_KEY:     return 32'(m_key);
            REG_KEYEDGE: return 32'(m_edge);
            REG_SW:      return 32'(m_sw);
            REG_TIMER:   return m_timer;
            REG_IRQEN:   return 32'(m_irqen);
            default:     return 32'h0;
        endcase
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // CPU-side access through the 0x100 window.
    task automatic rd(input string tag, input logic [2:0] idx, input logic [31:0] exp);
        logic [31:0] cpu_addr;
        cpu_addr = IO_BASE | 32'(reg_off(idx));
        sel  = cpu_addr[8];
        we   = 1'b0;
        addr = cpu_addr[4:0];
        #1;
        check(tag, rdata, exp);
    endtask

    task automatic wr(input logic [2:0] idx, input logic [31:0] d);
        logic [31:0] cpu_addr;
        cpu_addr = IO_BASE | 32'(reg_off(idx));
        sel   = cpu_addr[8];
        we    = 1'b1;
        addr  = cpu_addr[4:0];
        wdata = d;
        @(negedge clk);
        we  = 1'b0;
        sel = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; sel = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        key_n = '1; sw = '0;
        cycles(2);
        check("rst_ledr", 32'(ledr), 32'h0);
        check("rst_hex", 32'(hex_nib), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        for (int r = 0; r < 8; r++) begin
            @(negedge clk);
            rd($sformatf("rst_reg%0d", r), 3'(r), 32'h0);
        end
        sel = 1'b0; addr = 5'h14; #1;
        check("unsel_rd", rdata, 32'h0);
        reset = 1'b1;
        @(negedge clk);

        wr(REG_LEDS, 32'hFFFF_FFFF);
        check("ledr_out", 32'(ledr), 32'h3FF);
        rd("ledr_rd", REG_LEDS, 32'h3FF);
        wr(REG_HEX, 32'h00AB_CDEF);
        check("hex_out", 32'(hex_nib), 32'hABCDEF);
        rd("hex_rd", REG_HEX, 32'hABCDEF);

        // 3-sample glitch on key 1 must be rejected.
        key_n[1] = 1'b0;
        cycles(3);
        key_n[1] = 1'b1;
        cycles(6);
        rd("glitch_key", REG_KEY, 32'h0);
        rd("glitch_edge", REG_KEYEDGE, 32'h0);

        wr(REG_IRQEN, 32'h2);
        key_n[1] = 1'b0;
        cycles(5);
        rd("key1_early", REG_KEY, 32'h0);
        check("irq_early", 32'(irq), 32'h0);
        cycles(1);
        rd("key1_lvl", REG_KEY, 32'h2);
        rd("key1_edge", REG_KEYEDGE, 32'h2);
        check("key1_irq", 32'(irq), 32'h1);

        // W1C of key 1 on the same edge key 2 is accepted.
        key_n[2] = 1'b0;
        cycles(5);
        wr(REG_KEYEDGE, 32'h2);
        rd("race_edge", REG_KEYEDGE, 32'h4);
        check("race_irq", 32'(irq), 32'h0);
        rd("race_key", REG_KEY, 32'h6);

        key_n[1] = 1'b1;
        cycles(6);
        rd("rel_key", REG_KEY, 32'h4);
        rd("rel_edge", REG_KEYEDGE, 32'h4);

        // Set beats clear on the same bit.
        key_n[1] = 1'b0;
        cycles(5);
        wr(REG_KEYEDGE, 32'h2);
        rd("setwin_edge", REG_KEYEDGE, 32'h6);
        check("setwin_irq", 32'(irq), 32'h1);

        wr(REG_TIMER, 32'hFFFF_FFFE);
        rd("tmr_load", REG_TIMER, 32'hFFFF_FFFE);
        @(negedge clk);
        rd("tmr_inc", REG_TIMER, 32'hFFFF_FFFF);
        @(negedge clk);
        rd("tmr_wrap", REG_TIMER, 32'h0);

        wr(REG_KEY, 32'h0);
        rd("ro_key", REG_KEY, 32'h6);
        wr(REG_SW, 32'hFFFF_FFFF);
        rd("ro_sw", REG_SW, 32'h0);
        wr(REG_RSVD, 32'hFFFF_FFFF);
        rd("rsvd", REG_RSVD, 32'h0);
        wr(REG_KEYEDGE, 32'hF);
        rd("w1c_all", REG_KEYEDGE, 32'h0);
        check("w1c_irq", 32'(irq), 32'h0);

        // Reset two cycles into a switch change discards the partial count.
        sw = 10'h2A5;
        cycles(2);
        reset = 1'b0;
        cycles(2);
        reset = 1'b1;
        rd("midrst_sw", REG_SW, 32'h0);
        check("midrst_ledr", 32'(ledr), 32'h0);
        cycles(5);
        rd("midrst_early", REG_SW, 32'h0);
        cycles(1);
        rd("midrst_sw_lvl", REG_SW, 32'h2A5);

        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 5) == 0) begin
                int k;
                k = $urandom_range(0, KEY_W - 1);
                key_n[k] = ~key_n[k];
            end
            if ($urandom_range(0, 3) == 0) begin
                int s;
                s = $urandom_range(0, SW_W - 1);
                sw[s] = ~sw[s];
            end
            reset = ($urandom_range(0, 299) != 0);
            sel   = 1'($urandom_range(0, 1));
            we    = ($urandom_range(0, 3) == 0);
            addr  = 5'($urandom);
            wdata = $urandom;
            #1;
            check("rnd_rdata", rdata, model_rd(sel, addr));
            check("rnd_ledr", 32'(ledr), 32'(m_led));
            check("rnd_hex", 32'(hex_nib), 32'(m_hex));
            check("rnd_irq", 32'(irq), 32'(|(m_edge & m_irqen)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
